// File: rtl/demux_tdm_pkg.sv
// Shared constants, FSM state type and slot-offset helper for the 1:4 TDM demultiplexer.
package demux_tdm_pkg;

   localparam int SLOT_COUNT = 4;
   localparam int SEL_W      = 2;

   typedef enum logic {
      ST_HUNT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic int slot_lsb(input int k, input int width);
      return k * width;
   endfunction

endpackage

// File: rtl/demux_1_4_tdm_if.sv
// Stream, frame and status signals of demux_1_4_tdm. The optional parity pins exist only
// when DEMUX_PARITY_EN is defined.
interface demux_1_4_tdm_if
   import demux_tdm_pkg::*;
#(
   parameter int WIDTH = 8
) ();

   // valid_in qualifies d_in and sync_in; there is no backpressure, so every word presented
   // with valid_in=1 is consumed at that rising edge. frame_valid_out marks y_out as new.
   logic [WIDTH-1:0]            d_in;
   logic                        valid_in;
   logic                        sync_in;
   logic                        clr_err_in;
   logic [SLOT_COUNT*WIDTH-1:0] y_out;
   logic                        frame_valid_out;
   logic [SEL_W-1:0]            sel_out;
   logic                        locked_out;
   logic                        err_out;
`ifdef DEMUX_PARITY_EN
   logic                        parity_in;
   logic                        parity_err_out;
`endif

   modport master (
      output d_in, valid_in, sync_in, clr_err_in,
`ifdef DEMUX_PARITY_EN
      output parity_in,
      input  parity_err_out,
`endif
      input  y_out, frame_valid_out, sel_out, locked_out, err_out
   );

   modport slave (
      input  d_in, valid_in, sync_in, clr_err_in,
`ifdef DEMUX_PARITY_EN
      input  parity_in,
      output parity_err_out,
`endif
      output y_out, frame_valid_out, sel_out, locked_out, err_out
   );

endinterface

// File: rtl/demux_1_4_tdm_slot_counter.sv
// Mod-4 slot select counter: clear beats load-to-1, which beats increment.
module tdm_slot_counter
   import demux_tdm_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             en_in,
   input  logic             load1_in,
   input  logic             clr_in,
   output logic [SEL_W-1:0] cnt_out,
   output logic             term_out
);

   logic [SEL_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_in)        cnt_d = '0;
      else if (load1_in) cnt_d = SEL_W'(1);
      else if (en_in)    cnt_d = cnt_q + SEL_W'(1);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_out  = cnt_q;
   assign term_out = (cnt_q == SEL_W'(SLOT_COUNT - 1));

endmodule

// File: rtl/demux_1_4_tdm.sv
// Time-division 1:4 demultiplexer: locks on a sync-marked slot-0 word and emits one parallel
// frame per four accepted words. DEMUX_PARITY_EN adds per-word even-parity checking.
module demux_1_4_tdm
   import demux_tdm_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit SYNC_EVERY = 1'b0
) (
   input  logic             clk_in,
   input  logic             rst_in,
   demux_1_4_tdm_if.slave   bus
);

   state_e                      state_q, state_d;
   logic [WIDTH-1:0]            shadow_q [0:SLOT_COUNT-2];
   logic [WIDTH-1:0]            shadow_d [0:SLOT_COUNT-2];
   logic [SLOT_COUNT*WIDTH-1:0] y_q, y_d;
   logic                        fv_q, fv_d;
   logic                        err_q, err_d, err_event;
   logic                        wr_last;
   logic                        cnt_en, cnt_load1, cnt_clr;
   logic [SEL_W-1:0]            sel;
   logic                        sel_term;

   tdm_slot_counter u_slot_counter (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .en_in    (cnt_en),
      .load1_in (cnt_load1),
      .clr_in   (cnt_clr),
      .cnt_out  (sel),
      .term_out (sel_term)
   );

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      y_d       = y_q;
      err_event = 1'b0;
      wr_last   = 1'b0;
      cnt_en    = 1'b0;
      cnt_load1 = 1'b0;
      cnt_clr   = 1'b0;
      case (state_q)
         ST_HUNT: begin
            if (bus.valid_in && bus.sync_in) begin
               shadow_d[0] = bus.d_in;
               cnt_load1   = 1'b1;
               state_d     = ST_RUN;
            end
         end
         default: begin
            if (bus.valid_in) begin
               // A sync mid-frame restarts the frame at slot 0; the partial frame is dropped.
               if (bus.sync_in && sel != '0) begin
                  err_event   = 1'b1;
                  shadow_d[0] = bus.d_in;
                  cnt_load1   = 1'b1;
               end else if (SYNC_EVERY && sel == '0 && !bus.sync_in) begin
                  err_event = 1'b1;
                  cnt_clr   = 1'b1;
                  state_d   = ST_HUNT;
               end else begin
                  cnt_en = 1'b1;
                  if (sel_term) begin
                     wr_last = 1'b1;
                     for (int k = 0; k < SLOT_COUNT - 1; k++)
                        y_d[slot_lsb(k, WIDTH) +: WIDTH] = shadow_q[k];
                     y_d[slot_lsb(SLOT_COUNT - 1, WIDTH) +: WIDTH] = bus.d_in;
                  end else begin
                     for (int k = 0; k < SLOT_COUNT - 1; k++)
                        if (sel == SEL_W'(k)) shadow_d[k] = bus.d_in;
                  end
               end
            end
         end
      endcase
      // A new error in the same cycle as a clear leaves the flag set.
      err_d = (bus.clr_err_in ? 1'b0 : err_q) | err_event;
   end

`ifdef DEMUX_PARITY_EN
   logic par_bad, par_chk, frame_bad_q, frame_bad_d, perr_q, perr_d;

   always_comb begin
      par_bad     = (^bus.d_in) != bus.parity_in;
      par_chk     = bus.valid_in && (state_q == ST_RUN || bus.sync_in);
      frame_bad_d = frame_bad_q;
      if (par_chk)
         frame_bad_d = (bus.sync_in || sel == '0) ? par_bad : (frame_bad_q | par_bad);
      fv_d   = wr_last && !(frame_bad_q || par_bad);
      perr_d = (bus.clr_err_in ? 1'b0 : perr_q) | (par_chk & par_bad);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         frame_bad_q <= 1'b0;
         perr_q      <= 1'b0;
      end else begin
         frame_bad_q <= frame_bad_d;
         perr_q      <= perr_d;
      end
   end

   assign bus.parity_err_out = perr_q;
`else
   assign fv_d = wr_last;
`endif

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= ST_HUNT;
         shadow_q <= '{default: '0};
         y_q      <= '0;
         fv_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         y_q      <= y_d;
         fv_q     <= fv_d;
         err_q    <= err_d;
      end
   end

   assign bus.y_out           = y_q;
   assign bus.frame_valid_out = fv_q;
   assign bus.sel_out         = sel;
   assign bus.locked_out      = (state_q == ST_RUN);
   assign bus.err_out         = err_q;

endmodule

// File: tb/tb_demux_1_4_tdm.sv
// Self-checking bench for demux_1_4_tdm (WIDTH=8, SYNC_EVERY=0): directed scenarios plus random
// traffic against a frame-assembly reference model; frames are checked through an expected queue.
module tb_demux_1_4_tdm;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   demux_1_4_tdm_if #(.WIDTH(8)) bus ();

   demux_1_4_tdm #(.WIDTH(8), .SYNC_EVERY(1'b0)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the words collected so far for the frame being built.
   logic [7:0]  m_frame[$];
   bit          m_locked;
   bit          m_err;
   logic [31:0] m_y;
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_frame.delete();
      m_locked = 1'b0;
      m_err    = 1'b0;
      m_y      = '0;
      exp_q.delete();
   endtask

   task automatic model_step(input bit v, input bit s, input logic [7:0] d, input bit c);
      bit err_ev;
      err_ev = 1'b0;
      if (v) begin
         if (!m_locked) begin
            if (s) begin
               m_frame  = {d};
               m_locked = 1'b1;
            end
         end else if (s && m_frame.size() != 0) begin
            err_ev  = 1'b1;
            m_frame = {d};
         end else begin
            m_frame.push_back(d);
            if (m_frame.size() == 4) begin
               m_y = {m_frame[3], m_frame[2], m_frame[1], m_frame[0]};
               exp_q.push_back(m_y);
               m_frame.delete();
            end
         end
      end
      m_err = (c ? 1'b0 : m_err) | err_ev;
   endtask

   task automatic check_status();
      chk("sel_out", 32'(bus.sel_out), 32'(m_frame.size()));
      chk("locked_out", 32'(bus.locked_out), 32'(m_locked));
      chk("err_out", 32'(bus.err_out), 32'(m_err));
      chk("y_out_held", bus.y_out, m_y);
   endtask

   // Called just after a rising edge; applies one cycle of input and checks after the next edge.
   task automatic step(input bit v, input bit s, input logic [7:0] d, input bit c);
      bus.valid_in   = v;
      bus.sync_in    = s;
      bus.d_in       = d;
      bus.clr_err_in = c;
`ifdef DEMUX_PARITY_EN
      bus.parity_in  = ^d;
`endif
      model_step(v, s, d, c);
      @(posedge clk);
      #1;
      check_status();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   // Asserts reset between clock edges and checks outputs clear without waiting for an edge.
   task automatic reset_mid();
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("rst_y", bus.y_out, 32'h0);
      chk("rst_fv", 32'(bus.frame_valid_out), 32'h0);
      chk("rst_sel", 32'(bus.sel_out), 32'h0);
      chk("rst_locked", 32'(bus.locked_out), 32'h0);
      chk("rst_err", 32'(bus.err_out), 32'h0);
      @(negedge clk);
      #1 rst = 1'b0;
   endtask

   // Monitor: every frame pulse must match the next expected frame.
   always @(negedge clk) begin
      if (!rst && bus.frame_valid_out !== 1'b0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got fv=%b y=%h expected no pulse at %0t",
                     bus.frame_valid_out, bus.y_out, $time);
         end else begin
            chk("frame", bus.y_out, exp_q.pop_front());
         end
      end
   end

   task automatic drain_check(input string name);
      @(negedge clk);
      #1;
      chk(name, 32'(exp_q.size()), 32'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.valid_in   = 1'b0;
      bus.sync_in    = 1'b0;
      bus.d_in       = '0;
      bus.clr_err_in = 1'b0;
`ifdef DEMUX_PARITY_EN
      bus.parity_in  = 1'b0;
`endif
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("init_y", bus.y_out, 32'h0);
      chk("init_fv", 32'(bus.frame_valid_out), 32'h0);
      chk("init_sel", 32'(bus.sel_out), 32'h0);
      chk("init_locked", 32'(bus.locked_out), 32'h0);
      chk("init_err", 32'(bus.err_out), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Acquire and frame on consecutive cycles.
      step(1'b1, 1'b1, 8'hA0, 1'b0);
      step(1'b1, 1'b0, 8'hB1, 1'b0);
      step(1'b1, 1'b0, 8'hC2, 1'b0);
      step(1'b1, 1'b0, 8'hD3, 1'b0);
      chk("acq_y", bus.y_out, 32'hD3C2B1A0);
      chk("acq_fv", 32'(bus.frame_valid_out), 32'h1);
      chk("acq_locked", 32'(bus.locked_out), 32'h1);
      chk("acq_sel", 32'(bus.sel_out), 32'h0);
      idle(1);
      chk("acq_fv_one_cycle", 32'(bus.frame_valid_out), 32'h0);

      // Same frame with three idle cycles between words.
      step(1'b1, 1'b1, 8'hA0, 1'b0); idle(3);
      chk("gap_sel_hold", 32'(bus.sel_out), 32'h1);
      step(1'b1, 1'b0, 8'hB1, 1'b0); idle(3);
      step(1'b1, 1'b0, 8'hC2, 1'b0); idle(3);
      step(1'b1, 1'b0, 8'hD3, 1'b0); idle(3);
      chk("gap_y", bus.y_out, 32'hD3C2B1A0);
      drain_check("gap_pending");

      // Junk before lock is ignored.
      reset_mid();
      step(1'b1, 1'b0, 8'h11, 1'b0);
      step(1'b1, 1'b0, 8'h22, 1'b0);
      chk("junk_unlocked", 32'(bus.locked_out), 32'h0);
      step(1'b1, 1'b1, 8'h44, 1'b0);
      step(1'b1, 1'b0, 8'h55, 1'b0);
      step(1'b1, 1'b0, 8'h66, 1'b0);
      step(1'b1, 1'b0, 8'h77, 1'b0);
      chk("junk_y", bus.y_out, 32'h77665544);
      idle(1);

      // Misaligned sync drops the partial frame and flags an error.
      step(1'b1, 1'b1, 8'h10, 1'b0);
      step(1'b1, 1'b0, 8'h20, 1'b0);
      step(1'b1, 1'b1, 8'h30, 1'b0);
      chk("mis_err", 32'(bus.err_out), 32'h1);
      chk("mis_sel", 32'(bus.sel_out), 32'h1);
      step(1'b1, 1'b0, 8'h40, 1'b0);
      step(1'b1, 1'b0, 8'h50, 1'b0);
      step(1'b1, 1'b0, 8'h60, 1'b0);
      chk("mis_y", bus.y_out, 32'h60504030);
      idle(1);

      // Clear, then clear coinciding with a new error.
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("clr_err", 32'(bus.err_out), 32'h0);
      step(1'b1, 1'b1, 8'h10, 1'b0);
      step(1'b1, 1'b0, 8'h20, 1'b0);
      step(1'b1, 1'b1, 8'h30, 1'b1);
      chk("clr_vs_err", 32'(bus.err_out), 32'h1);
      step(1'b1, 1'b0, 8'h40, 1'b0);
      step(1'b1, 1'b0, 8'h50, 1'b0);
      step(1'b1, 1'b0, 8'h60, 1'b0);
      step(1'b0, 1'b1, 8'h99, 1'b0);
      chk("sync_without_valid", 32'(bus.sel_out), 32'h0);
      drain_check("clr_pending");

      // Reset mid-frame; unsynced remainder must not produce a frame.
      step(1'b1, 1'b1, 8'hA0, 1'b0);
      step(1'b1, 1'b0, 8'hB1, 1'b0);
      reset_mid();
      step(1'b1, 1'b0, 8'hC2, 1'b0);
      step(1'b1, 1'b0, 8'hD3, 1'b0);
      idle(2);
      chk("rst_no_frame_y", bus.y_out, 32'h0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         bit v, s, c;
         v = ($urandom_range(0, 9) < 7);
         if (m_frame.size() == 0) s = ($urandom_range(0, 9) < 8);
         else                     s = ($urandom_range(0, 19) == 0);
         c = ($urandom_range(0, 29) == 0);
         step(v, s, 8'($urandom_range(0, 255)), c);
      end
      drain_check("final_pending");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux_1_4_tdm.md
Name: demux_1_4_tdm

Overview:
- Receive-side counterpart of the team's 4:1 mux family: a time-division 1-to-4 demultiplexer.
- Accepts a serial stream of words on one input, one word per slot. Slot 0 is marked by a sync flag.
- Routes each word to the slot register selected by an internal rotating select counter.
- Presents all four words as one parallel frame once slot 3 arrives. Sits at the far end of a 4:1 TDM link.

Parameters:
- WIDTH, 8, bits per slot word.
- SYNC_EVERY, 0, 1 = sync_in required on every slot-0 word (a missing sync is an error); 0 = sync only needed to acquire lock.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  asynchronous active-high reset.
- d_in  input  WIDTH  serial slot word.
- valid_in  input  1  d_in carries a word this cycle.
- sync_in  input  1  current word is slot 0; only meaningful when valid_in=1.
- clr_err_in  input  1  synchronous clear of err_out.
- y_out  output  4*WIDTH  last complete frame; slot k at bits [k*WIDTH +: WIDTH].
- frame_valid_out  output  1  one-cycle pulse: y_out updated this cycle.
- sel_out  output  2  slot index the next accepted word will fill.
- locked_out  output  1  FSM in RUN.
- err_out  output  1  sticky alignment error.

Behaviour:
- One clock; reset asynchronous, active-high. All state is registered on the rising edge of clk_in.
- Reset values: y_out=0, frame_valid_out=0, sel_out=0, locked_out=0, err_out=0, shadow registers=0, FSM=HUNT.
- FSM states are HUNT and RUN.
- HUNT:
  - Words with sync_in=0 are discarded.
  - valid_in=1 with sync_in=1: write d_in to shadow[0], set sel=1, go to RUN.
- RUN, accepted word (valid_in=1):
  - Write d_in to shadow[sel]; sel increments mod 4.
  - On a write to slot 3, y_out is loaded with {d_in, shadow[2], shadow[1], shadow[0]} at the same edge, so slot 3 bypasses its shadow register.
  - frame_valid_out=1 for exactly the cycle after that edge.
  - Latency: frame visible one clock after the slot-3 word is sampled.
- valid_in=0: no state change; sel holds; frame_valid_out=0. Gaps between slots are legal.
- Misalignment (RUN, valid_in=1, sync_in=1, sel!=0):
  - Set err_out.
  - Discard the partial frame: y_out is not updated and no pulse is generated.
  - Store the word as slot 0 and set sel=1. Stay in RUN.
- Missing sync, SYNC_EVERY=1 only (RUN, valid_in=1, sel=0, sync_in=0):
  - Set err_out, discard the word, go to HUNT, set sel=0.
- sync_in while valid_in=0: ignored.
- clr_err_in=1 clears err_out. If clr_err_in and a new error event occur in the same cycle, the error wins and err_out=1.
- sel_out equals the internal sel. locked_out=1 exactly while in RUN.
- Reset mid-frame: all shadow contents are lost and the FSM returns to HUNT. No frame_valid_out pulse for the partial frame.

Optional Feature:
- Macro: DEMUX_PARITY_EN.
- Defined:
  - Adds input parity_in (1 bit, even parity over d_in) and output parity_err_out (1 bit, sticky, reset 0).
  - Parity is checked on every accepted word in RUN and on the acquiring sync word in HUNT.
  - On a mismatch: set parity_err_out. If the mismatch occurs anywhere in a frame, y_out still updates but frame_valid_out is suppressed for that frame.
  - clr_err_in also clears parity_err_out.
- Undefined: no parity port, no parity check, behaviour exactly as above.

Decomposition:
- Package demux_tdm_pkg holds:
  - SLOT_COUNT=4 and SEL_W=2.
  - State enum constants ST_HUNT=1'b0 and ST_RUN=1'b1.
  - Function slot_lsb(k) returning k*WIDTH.
- One natural sub-module, tdm_slot_counter: 2-bit mod-4 counter with enable, synchronous load-to-1 and clear, and a terminal flag at count 3.

Test Plan:
- Acquire and frame: WIDTH=8; words A0(sync),B1,C2,D3 on consecutive cycles -> one cycle after D3, y_out=32'hD3C2B1A0, frame_valid_out=1 for one cycle, locked_out=1, sel_out=0.
- Gaps: same four words with valid_in low for 3 cycles between each -> identical y_out; sel_out holds across gaps; exactly one pulse.
- Pre-lock junk: words 11,22 with sync_in=0, then 44(sync),55,66,77 -> y_out=32'h77665544; 11 and 22 never appear in y_out.
- Misalignment: 10(sync),20, then 30(sync),40,50,60 -> err_out=1 from the 30 edge; the partial frame gives no pulse; y_out=32'h60504030.
- Sticky clear and priority: with err_out=1, pulse clr_err_in -> 0; assert clr_err_in in the same cycle as a misaligning sync -> err_out=1.
- Async reset mid-frame: assert rst_in between the B1 and C2 words (not on an edge) -> outputs zero immediately, FSM in HUNT. A following unsynced C2,D3 produces no pulse.
